pixel_output_formatter: RTL

//  Sits directly downstream of the decoder output buffers. Accepts the raster-ordered 4-pixel/cycle stream (14b signed/comp).

---
 rtl/pixel_output_formatter_if.sv | 25 ++
 rtl/pixel_output_formatter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_output_formatter_if.sv
// Stream bundle for pixel_output_formatter: non-stallable 4-pixel input word
// and the ready/valid tagged output word.
interface pixel_output_formatter_if;
   logic         in_sof;
   logic [167:0] in_data_p;
   logic         in_data_valid;
   logic         out_ready;
   logic         out_valid;
   logic [143:0] out_data_p;
   logic [3:0]   out_pix_mask;
   logic         out_sof;
   logic         out_sol;
   logic         out_eol;
   logic         out_eof;

   modport master (
      output in_sof, in_data_p, in_data_valid, out_ready,
      input  out_valid, out_data_p, out_pix_mask, out_sof, out_sol, out_eol, out_eof
   );

   modport slave (
      input  in_sof, in_data_p, in_data_valid, out_ready,
      output out_valid, out_data_p, out_pix_mask, out_sof, out_sol, out_eol, out_eof
   );
endinterface

// File: rtl/pixel_output_formatter.sv
// Clips decoder pixels to the coded bit depth, tags line/frame boundaries and
// the valid-pixel mask, and buffers words in a show-ahead FIFO for a ready/valid sink.
module pixel_output_formatter #(
   parameter int MAX_SLICE_WIDTH  = 2560,
   parameter int MAX_SLICE_HEIGHT = 4096,
   parameter int FIFO_DEPTH       = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 flush,
   input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]   slice_width,
   input  logic [$clog2(MAX_SLICE_HEIGHT)-1:0]  slice_height,
   input  logic [3:0]                           bits_per_component,
   pixel_output_formatter_if.slave              bus,
   output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
   output logic                                 overflow,
   output logic                                 frame_err
);
   localparam int WW = $clog2(MAX_SLICE_WIDTH);
   localparam int HW = $clog2(MAX_SLICE_HEIGHT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 144 + 4 + 4;

   typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

   function automatic logic [11:0] clip_comp(input logic signed [13:0] v, input logic [3:0] bpc);
      logic [12:0] maxval;
      maxval = (bpc >= 4'd12) ? 13'd4095 : 13'((13'd1 << bpc) - 13'd1);
      if (v < 0)
         clip_comp = 12'd0;
      else if ($signed({1'b0, maxval}) < v)
         clip_comp = maxval[11:0];
      else
         clip_comp = v[11:0];
   endfunction

   state_t          state_q, state_d;
   logic [WW-1:0]   col_q, col_d, width_q, width_d;
   logic [HW-1:0]   row_q, row_d, height_q, height_d;
   logic [3:0]      bpc_q, bpc_d;
   logic            frame_err_q, frame_err_d;
   logic            s1_valid_q, s1_valid_d;
   logic [143:0]    s1_data_q, s1_data_d;
   logic [3:0]      s1_mask_q, s1_mask_d;
   logic [3:0]      s1_tags_q, s1_tags_d;
   logic [AW:0]     wr_ptr_q, rd_ptr_q;
   logic            overflow_q;
   logic [EW-1:0]   mem_q [FIFO_DEPTH];

   // The sof word (ARMED, or in_sof this cycle) uses live config and zeroed counters.
   logic            start_w, accept_w, eol_w, eof_w;
   logic [WW-1:0]   cfg_w, col_cur, wpl_m1;
   logic [WW:0]     wpl_ext;
   logic [HW-1:0]   cfg_h, row_cur;
   logic [3:0]      cfg_bpc, mask_w;
   logic [1:0]      rem_w;
   logic [143:0]    clip_data_w;

   assign start_w  = bus.in_sof || (state_q == ARMED);
   assign accept_w = bus.in_data_valid && (start_w || (state_q == ACTIVE));
   assign cfg_w    = start_w ? slice_width        : width_q;
   assign cfg_h    = start_w ? slice_height       : height_q;
   assign cfg_bpc  = start_w ? bits_per_component : bpc_q;
   assign col_cur  = start_w ? '0 : col_q;
   assign row_cur  = start_w ? '0 : row_q;
   assign wpl_ext  = ({1'b0, cfg_w} + (WW+1)'(3)) >> 2;
   assign wpl_m1   = wpl_ext[WW-1:0] - WW'(1);
   assign rem_w    = cfg_w[1:0];
   assign eol_w    = (col_cur == wpl_m1);
   assign eof_w    = eol_w && (row_cur == cfg_h - HW'(1));
   assign mask_w   = (eol_w && rem_w != 2'd0) ? 4'((4'd1 << rem_w) - 4'd1) : 4'hF;

   for (genvar gi = 0; gi < 12; gi++) begin : g_clip
      assign clip_data_w[gi*12 +: 12] =
         clip_comp(bus.in_data_p[gi*14 +: 14], cfg_bpc) & {12{mask_w[gi/3]}};
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      width_d     = width_q;
      height_d    = height_q;
      bpc_d       = bpc_q;
      frame_err_d = frame_err_q;
      s1_valid_d  = 1'b0;
      s1_data_d   = '0;
      s1_mask_d   = '0;
      s1_tags_d   = '0;
      if (bus.in_sof) begin
         state_d = ARMED;
         col_d   = '0;
         row_d   = '0;
         if (state_q == ACTIVE) frame_err_d = 1'b1;
      end
      if (bus.in_data_valid && !accept_w) frame_err_d = 1'b1;
      if (accept_w) begin
         s1_valid_d = 1'b1;
         s1_data_d  = clip_data_w;
         s1_mask_d  = mask_w;
         s1_tags_d  = {start_w, col_cur == '0, eol_w, eof_w};
         if (start_w) begin
            width_d  = slice_width;
            height_d = slice_height;
            bpc_d    = bits_per_component;
         end
         if (eol_w) begin
            col_d   = '0;
            row_d   = row_cur + HW'(1);
            state_d = eof_w ? IDLE : ACTIVE;
         end else begin
            col_d   = col_cur + WW'(1);
            state_d = ACTIVE;
         end
      end
   end

   logic          full_w, pop_w, push_ok_w;
   logic [EW-1:0] head_w;

   assign fifo_level    = wr_ptr_q - rd_ptr_q;
   assign full_w        = (fifo_level == (AW+1)'(FIFO_DEPTH));
   assign bus.out_valid = (wr_ptr_q != rd_ptr_q);
   assign pop_w         = bus.out_valid && bus.out_ready;
   assign push_ok_w     = s1_valid_q && (!full_w || pop_w);
   assign head_w        = bus.out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

   assign bus.out_data_p   = head_w[EW-1:8];
   assign bus.out_pix_mask = head_w[7:4];
   assign bus.out_sof      = head_w[3];
   assign bus.out_sol      = head_w[2];
   assign bus.out_eol      = head_w[1];
   assign bus.out_eof      = head_w[0];
   assign overflow         = overflow_q;
   assign frame_err        = frame_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         width_q     <= '0;
         height_q    <= '0;
         bpc_q       <= '0;
         frame_err_q <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_mask_q   <= '0;
         s1_tags_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
      end else if (flush) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         frame_err_q <= 1'b0;
         s1_valid_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         width_q     <= width_d;
         height_q    <= height_d;
         bpc_q       <= bpc_d;
         frame_err_q <= frame_err_d;
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_mask_q   <= s1_mask_d;
         s1_tags_q   <= s1_tags_d;
         if (push_ok_w) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop_w)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         if (s1_valid_q && !push_ok_w) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok_w && !flush)
         mem_q[wr_ptr_q[AW-1:0]] <= {s1_data_q, s1_mask_q, s1_tags_q};
   end
endmodule
